// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states, error codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD_A    = 3'b000,
        OP_LOAD_B    = 3'b001,
        OP_STORE     = 3'b010,
        OP_STORE_IMM = 3'b011,
        OP_JMP       = 3'b100,
        OP_ILLEGAL   = 3'b101,
        OP_RET       = 3'b110,
        OP_ALU       = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_FETCH_TO = 2'b10,
        ERR_DATA_TO  = 2'b11
    } err_code_t;

    function automatic logic op_is_load(input opcode_t op);
        return (op == OP_LOAD_A) || (op == OP_LOAD_B);
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Memory request/acknowledge handshake between the control unit and variable-latency memory.
interface multi_cycle_control_unit_if;
    logic mem_req;
    logic rd_mem;
    logic wr_mem;
    logic imm;
    logic mem_ack;

    modport master (output mem_req, output rd_mem, output wr_mem, output imm, input mem_ack);
    modport slave  (input mem_req, input rd_mem, input wr_mem, input imm, output mem_ack);
endinterface

// File: rtl/multi_cycle_control_unit_timer.sv
// Wait-cycle counter for memory phases; expired is high on the last allowed cycle.
module cu_timeout_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign expired = (count_q == W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the accumulator core with
// memory timeout, illegal-opcode detection, sticky error and retired counter.
module multi_cycle_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [OPCODE_W-1:0]         opcode,
    input  logic                        err_clr,
    multi_cycle_control_unit_if.master  mem,
    output logic                        ir_load,
    output logic                        pc_inc,
    output logic                        load_A,
    output logic                        load_B,
    output logic                        wb_A,
    output logic                        jmp,
    output logic                        ret,
    output logic                        busy,
    output logic                        error,
    output logic [1:0]                  err_code,
    output logic [CNT_W-1:0]            retired_cnt
);
    state_t     state_q, state_d;
    opcode_t    op_q, op_d;
    err_code_t  err_code_q, err_code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic    opcode_legal;
    logic    tmr_clr;
    logic    tmr_run;
    logic    tmr_expired;
    opcode_t opcode_low;

    assign opcode_low   = opcode_t'(opcode[2:0]);
    assign opcode_legal = ((opcode >> 3) == '0) && (opcode_low != OP_ILLEGAL);

    // Holding the timer clear outside the two wait states makes it start at 0 on entry.
    assign tmr_clr = !((state_q == S_FETCH) || (state_q == S_MEM));
    assign tmr_run = !tmr_clr && !mem.mem_ack;

    cu_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (en) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem.mem_ack) begin
                    state_d = S_DECODE;
                end else if (tmr_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_FETCH_TO;
                end
            end
            S_DECODE: begin
                op_d = opcode_low;
                if (opcode_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d    = S_ERR;
                    err_code_d = ERR_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_JMP, OP_RET: begin
                        state_d = S_IDLE;
                        cnt_d   = cnt_q + 1'b1;
                    end
                    OP_ALU:  state_d = S_WB;
                    default: state_d = S_MEM;
                endcase
            end
            S_MEM: begin
                if (mem.mem_ack) begin
                    state_d = S_IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end else if (tmr_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_DATA_TO;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                cnt_d   = cnt_q + 1'b1;
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d    = S_IDLE;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= OP_LOAD_A;
            err_code_q <= ERR_NONE;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            err_code_q <= err_code_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        mem.mem_req = 1'b0;
        mem.rd_mem  = 1'b0;
        mem.wr_mem  = 1'b0;
        mem.imm     = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        load_A      = 1'b0;
        load_B      = 1'b0;
        wb_A        = 1'b0;
        jmp         = 1'b0;
        ret         = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                mem.rd_mem  = 1'b1;
                ir_load     = mem.mem_ack;
                pc_inc      = mem.mem_ack;
            end
            S_EXEC: begin
                jmp = (op_q == OP_JMP);
                ret = (op_q == OP_RET);
            end
            S_MEM: begin
                mem.mem_req = 1'b1;
                mem.rd_mem  = op_is_load(op_q);
                mem.wr_mem  = !op_is_load(op_q);
                mem.imm     = (op_q == OP_STORE_IMM);
                load_A      = mem.mem_ack && (op_q == OP_LOAD_A);
                load_B      = mem.mem_ack && (op_q == OP_LOAD_B);
            end
            S_WB: wb_A = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_ERR);
    assign error       = (state_q == S_ERR);
    assign err_code    = err_code_q;
    assign retired_cnt = cnt_q;
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Randomized bench: a per-instruction reference model expands each instruction into
// an expected cycle trace that is replayed against the control unit.
module tb_multi_cycle_control_unit;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned TIMEOUT  = 4;
    localparam int unsigned CNT_W    = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [OPCODE_W-1:0] opcode;
    logic err_clr;
    logic ir_load, pc_inc, load_A, load_B, wb_A, jmp, ret, busy, error;
    logic [1:0] err_code;
    logic [CNT_W-1:0] retired_cnt;

    multi_cycle_control_unit_if mif();

    multi_cycle_control_unit #(
        .OPCODE_W (OPCODE_W),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .opcode      (opcode),
        .err_clr     (err_clr),
        .mem         (mif),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .load_A      (load_A),
        .load_B      (load_B),
        .wb_A        (wb_A),
        .jmp         (jmp),
        .ret         (ret),
        .busy        (busy),
        .error       (error),
        .err_code    (err_code),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    logic [14:0] got_outs;
    assign got_outs = {mif.mem_req, mif.rd_mem, mif.wr_mem, mif.imm, ir_load, pc_inc,
                       load_A, load_B, wb_A, jmp, ret, busy, error, err_code};

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        ack;
        logic        clr;
        logic [3:0]  op;
        logic [14:0] outs;
        logic [2:0]  cnt;
    } cyc_t;

    cyc_t        trace[$];
    int unsigned model_cnt = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [14:0] ov(input bit req, rd, wr, im, irl, pci, la, lb, wb, j, r,
                                        bz, er, input logic [1:0] ec);
        return {req, rd, wr, im, irl, pci, la, lb, wb, j, r, bz, er, ec};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(15, 0));
    endfunction

    task automatic push(input logic rst, e, a, c, input logic [3:0] op, input logic [14:0] outs);
        cyc_t t;
        t.rst_n = rst; t.en = e; t.ack = a; t.clr = c; t.op = op; t.outs = outs;
        t.cnt = 3'(model_cnt);
        trace.push_back(t);
    endtask

    task automatic retire();
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic do_err(input logic [1:0] ec);
        int unsigned n = $urandom_range(2, 0);
        for (int unsigned i = 0; i < n; i++)
            push(1, rb(), rb(), 0, rop(), ov(0,0,0,0,0,0,0,0,0,0,0,0,1,ec));
        push(1, rb(), rb(), 1, rop(), ov(0,0,0,0,0,0,0,0,0,0,0,0,1,ec));
    endtask

    // One instruction: df/dm = wait cycles before ack in fetch/data phase (>=TIMEOUT means never).
    task automatic run_instr(input logic [3:0] op, input int unsigned df, input int unsigned dm);
        int unsigned nidle = $urandom_range(2, 0);
        logic [2:0] lo = op[2:0];
        bit is_load = (lo == 3'b000) || (lo == 3'b001);
        for (int unsigned i = 0; i < nidle; i++)
            push(1, 0, rb(), rb(), rop(), '0);
        push(1, 1, rb(), rb(), rop(), '0);
        for (int unsigned k = 0; k < TIMEOUT; k++) begin
            if (k == df) begin
                push(1, rb(), 1, 0, rop(), ov(1,1,0,0,1,1,0,0,0,0,0,1,0,2'b00));
                break;
            end
            push(1, rb(), 0, 0, rop(), ov(1,1,0,0,0,0,0,0,0,0,0,1,0,2'b00));
        end
        if (df >= TIMEOUT) begin
            do_err(2'b10);
            return;
        end
        push(1, rb(), rb(), 0, op, ov(0,0,0,0,0,0,0,0,0,0,0,1,0,2'b00));
        if (op[3] || lo == 3'b101) begin
            do_err(2'b01);
            return;
        end
        if (lo == 3'b100 || lo == 3'b110) begin
            push(1, rb(), rb(), 0, rop(),
                 ov(0,0,0,0,0,0,0,0,0,lo == 3'b100,lo == 3'b110,1,0,2'b00));
            retire();
            return;
        end
        push(1, rb(), rb(), 0, rop(), ov(0,0,0,0,0,0,0,0,0,0,0,1,0,2'b00));
        if (lo == 3'b111) begin
            push(1, rb(), rb(), 0, rop(), ov(0,0,0,0,0,0,0,0,1,0,0,1,0,2'b00));
            retire();
            return;
        end
        for (int unsigned k = 0; k < TIMEOUT; k++) begin
            if (k == dm) begin
                push(1, rb(), 1, 0, rop(), ov(1, is_load, !is_load, lo == 3'b011, 0, 0,
                                             lo == 3'b000, lo == 3'b001, 0,0,0,1,0,2'b00));
                retire();
                return;
            end
            push(1, rb(), 0, 0, rop(), ov(1, is_load, !is_load, lo == 3'b011, 0,0,0,0,0,0,0,1,0,2'b00));
        end
        do_err(2'b11);
    endtask

    task automatic reset_in_mem();
        push(1, 1, 0, 0, rop(), '0);
        push(1, 0, 1, 0, rop(), ov(1,1,0,0,1,1,0,0,0,0,0,1,0,2'b00));
        push(1, 0, 0, 0, 4'b0000, ov(0,0,0,0,0,0,0,0,0,0,0,1,0,2'b00));
        push(1, 0, 0, 0, rop(), ov(0,0,0,0,0,0,0,0,0,0,0,1,0,2'b00));
        push(1, 0, 0, 0, rop(), ov(1,1,0,0,0,0,0,0,0,0,0,1,0,2'b00));
        push(0, 0, 0, 0, rop(), ov(1,1,0,0,0,0,0,0,0,0,0,1,0,2'b00));
        model_cnt = 0;
        push(1, 0, 0, 0, rop(), '0);
        push(1, 0, 0, 0, rop(), '0);
    endtask

    function automatic int unsigned rdelay();
        return ($urandom_range(9, 0) == 0) ? TIMEOUT : $urandom_range(TIMEOUT - 1, 0);
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; err_clr = 1'b0; opcode = '0; mif.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_outs", 32'(got_outs), 32'd0);
        check_eq("reset_cnt", 32'(retired_cnt), 32'd0);

        run_instr(4'b0111, 0, 0);
        run_instr(4'b0000, 0, 3);
        run_instr(4'b0011, 1, 2);
        run_instr(4'b0010, 0, 1);
        run_instr(4'b0001, 2, 0);
        run_instr(4'b0101, 0, 0);
        run_instr(4'b1000, 1, 0);
        run_instr(4'b0100, TIMEOUT, 0);
        run_instr(4'b0110, TIMEOUT - 1, 0);
        run_instr(4'b0000, 0, TIMEOUT - 1);
        run_instr(4'b0010, 0, TIMEOUT);
        for (int i = 0; i < 9; i++) run_instr(4'b0100, 0, 0);
        reset_in_mem();
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op = rop();
            if ($urandom_range(3, 0) != 0) op[3] = 1'b0;
            run_instr(op, rdelay(), rdelay());
        end
        reset_in_mem();

        foreach (trace[i]) begin
            @(negedge clk);
            cyc         = i;
            rst_n       = trace[i].rst_n;
            en          = trace[i].en;
            mif.mem_ack = trace[i].ack;
            err_clr     = trace[i].clr;
            opcode      = trace[i].op;
            #1;
            check_eq("outs", 32'(got_outs), 32'(trace[i].outs));
            check_eq("retired_cnt", 32'(retired_cnt), 32'(trace[i].cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
